// File: rtl/traffic_pkg.sv
// Shared types and constants for the synthetic traffic source.
package traffic_pkg;
  typedef enum logic [1:0] {MODE_FIXED = 2'd0, MODE_RR = 2'd1, MODE_LFSR = 2'd2, MODE_RSVD = 2'd3} mode_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_e;

  localparam logic [15:0] LfsrTaps = 16'hB400;
  localparam int          SrcIdW   = 8;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
  endfunction
endpackage

// File: rtl/traffic_src_if.sv
// Packet stream between the traffic source and a switch input port.
interface traffic_src_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 2
);
  logic [DataWidth-1:0] data;
  logic [AddrWidth-1:0] addr;
  logic                 valid;
  logic                 ready;

  modport master (output data, addr, valid, input ready);
  modport slave  (input data, addr, valid, output ready);
endinterface

// File: rtl/traffic_src_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and enable-gated advance.
module lfsr16 import traffic_pkg::*; #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        en_i,
  output logic [15:0] state_o
);
  logic [15:0] state_d, state_q;

  always_comb begin
    state_d = state_q;
    if (load_i)    state_d = Seed;
    else if (en_i) state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= Seed;
    else         state_q <= state_d;
  end

  assign state_o = state_q;
endmodule

// File: rtl/traffic_src.sv
// Synthetic packet injector: programmed-length runs with gap and destination pattern.
// Optional stall counter output enabled by TRAFFIC_SRC_STALL_CNT_EN.
module traffic_src import traffic_pkg::*; #(
  parameter int          NumDst    = 4,
  parameter int          DataWidth = 32,
  parameter int          CntWidth  = 16,
  parameter logic [7:0]  SrcId     = 8'h00,
  parameter logic [15:0] LfsrSeed  = 16'hACE1,
  parameter int          AddrWidth = (NumDst > 1) ? $clog2(NumDst) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CntWidth-1:0]  num_pkts_i,
  input  logic [7:0]           rate_i,
  input  logic [1:0]           mode_i,
  input  logic [AddrWidth-1:0] fixed_dst_i,
  traffic_src_if.master        pkt,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CntWidth-1:0]  sent_cnt_o
`ifdef TRAFFIC_SRC_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);
  state_e               state_d, state_q;
  mode_e                mode_d, mode_q;
  logic [CntWidth-1:0]  num_d, num_q, seq_d, seq_q, sent_d, sent_q;
  logic [7:0]           rate_d, rate_q, gap_d, gap_q;
  logic [AddrWidth-1:0] fixed_d, fixed_q, rr_d, rr_q, dst;
  logic                 done_d, done_q;
  logic [15:0]          lfsr;
  logic                 start_ok, hs, last;

  assign start_ok = (state_q == ST_IDLE) && start_i && (num_pkts_i != '0);
  assign hs       = pkt.valid & pkt.ready;
  assign last     = (seq_q == num_q - 1'b1);

  lfsr16 #(.Seed(LfsrSeed)) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (start_ok),
    .en_i   (hs),
    .state_o(lfsr)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_SEND;
      ST_SEND: if (hs) begin
        if (last)              state_d = ST_IDLE;
        else if (rate_q != '0) state_d = ST_GAP;
      end
      ST_GAP:  if (gap_q == 8'd1) state_d = ST_SEND;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reserved mode falls through to the fixed destination.
  always_comb begin
    case (mode_q)
      MODE_RR:   dst = rr_q;
      MODE_LFSR: dst = AddrWidth'(32'(lfsr) % NumDst);
      default:   dst = AddrWidth'(32'(fixed_q) % NumDst);
    endcase
  end

  always_comb begin
    pkt.valid = (state_q == ST_SEND);
    pkt.data  = '0;
    pkt.addr  = '0;
    if (state_q == ST_SEND) begin
      pkt.data[DataWidth-1 -: SrcIdW] = SrcId;
      pkt.data[CntWidth-1:0]          = seq_q;
      pkt.addr                        = dst;
    end
    busy_o     = (state_q != ST_IDLE);
    done_o     = done_q;
    sent_cnt_o = sent_q;
  end

  always_comb begin
    num_d   = num_q;
    rate_d  = rate_q;
    mode_d  = mode_q;
    fixed_d = fixed_q;
    seq_d   = seq_q;
    sent_d  = sent_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    if ((state_q == ST_IDLE) && start_i) begin
      sent_d = '0;
      if (num_pkts_i == '0) begin
        done_d = 1'b1;
      end else begin
        num_d   = num_pkts_i;
        rate_d  = rate_i;
        mode_d  = mode_e'(mode_i);
        fixed_d = fixed_dst_i;
        seq_d   = '0;
        rr_d    = '0;
      end
    end
    if (hs) begin
      seq_d  = seq_q + 1'b1;
      sent_d = sent_q + 1'b1;
      rr_d   = (rr_q == AddrWidth'(NumDst - 1)) ? '0 : rr_q + 1'b1;
      gap_d  = rate_q;
      done_d = last;
    end else if (state_q == ST_GAP) begin
      gap_d = gap_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      num_q   <= '0;
      rate_q  <= '0;
      mode_q  <= MODE_FIXED;
      fixed_q <= '0;
      seq_q   <= '0;
      sent_q  <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      num_q   <= num_d;
      rate_q  <= rate_d;
      mode_q  <= mode_d;
      fixed_q <= fixed_d;
      seq_q   <= seq_d;
      sent_q  <= sent_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

`ifdef TRAFFIC_SRC_STALL_CNT_EN
  logic [31:0] stall_d, stall_q;

  always_comb begin
    stall_d = stall_q;
    if (start_ok)                                          stall_d = '0;
    else if (pkt.valid && !pkt.ready && (stall_q != '1))   stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif
endmodule
